// File: rtl/fpadd_issue_ctrl.sv
// Issue controller sharing one fixed-latency FP adder between two requesters:
// round-robin issue, in-flight tracking, credited per-requester response FIFOs.
module fpadd_issue_ctrl #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [63:0]     i_req0_a,
  input  logic [63:0]     i_req0_b,
  input  logic [2:0]      i_req0_op,
  input  logic [TAGW-1:0] i_req0_tag,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [63:0]     i_req1_a,
  input  logic [63:0]     i_req1_b,
  input  logic [2:0]      i_req1_op,
  input  logic [TAGW-1:0] i_req1_tag,
  output logic            o_add_valid,
  output logic [63:0]     o_add_a,
  output logic [63:0]     o_add_b,
  output logic [2:0]      o_add_op,
  input  logic            i_add_res_valid,
  input  logic [63:0]     i_add_res,
  input  logic [4:0]      i_add_flags,
  output logic            o_resp0_valid,
  input  logic            i_resp0_ready,
  output logic [63:0]     o_resp0_data,
  output logic [4:0]      o_resp0_flags,
  output logic [TAGW-1:0] o_resp0_tag,
  output logic            o_resp1_valid,
  input  logic            i_resp1_ready,
  output logic [63:0]     o_resp1_data,
  output logic [4:0]      o_resp1_flags,
  output logic [TAGW-1:0] o_resp1_tag,
  output logic [4:0]      o_sticky0,
  output logic [4:0]      o_sticky1,
  input  logic [1:0]      i_sticky_clr,
  output logic            o_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CredMax = CW'(DEPTH);
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

  logic [1:0]      w_valid, w_resp_ready, w_elig, w_gnt, w_pop, w_push, w_release, w_full;
  logic            w_res_valid, w_drop, w_err_set;
  logic            w_tail_valid, w_tail_id;
  logic [TAGW-1:0] w_tail_tag;

  logic            r_last1;
  logic            r_add_valid, r_add_id;
  logic [63:0]     r_add_a, r_add_b;
  logic [2:0]      r_add_op;
  logic [TAGW-1:0] r_add_tag;
  logic [LAT-1:0]  r_sr_valid, r_sr_id;
  logic [TAGW-1:0] r_sr_tag [LAT];
  logic [BW-1:0]   r_blank;
  logic [CW-1:0]   r_cred [2];
  logic [AW:0]     r_cnt [2];
  logic [AW-1:0]   r_rd [2];
  logic [AW-1:0]   r_wr [2];
  logic [63:0]     r_mem_data [2][DEPTH];
  logic [4:0]      r_mem_flags [2][DEPTH];
  logic [TAGW-1:0] r_mem_tag [2][DEPTH];
  logic [4:0]      r_sticky [2];
  logic            r_err;

  assign w_valid      = {i_req1_valid, i_req0_valid};
  assign w_resp_ready = {i_resp1_ready, i_resp0_ready};
  assign w_tail_valid = r_sr_valid[LAT-1];
  assign w_tail_id    = r_sr_id[LAT-1];
  assign w_tail_tag   = r_sr_tag[LAT-1];
  // Results of ops issued before a reset can still emerge for LAT cycles; ignore them.
  assign w_res_valid  = i_add_res_valid & (r_blank == '0);

  always_comb begin
    w_elig    = '0;
    w_full    = '0;
    w_pop     = '0;
    w_push    = '0;
    w_release = '0;
    for (int n = 0; n < 2; n++) begin
      w_elig[n] = w_valid[n] & (r_cred[n] < CredMax);
      w_full[n] = (r_cnt[n] == CntFull);
      w_pop[n]  = (r_cnt[n] != '0) & w_resp_ready[n];
    end
    w_gnt[0]  = w_elig[0] & (~w_elig[1] | r_last1);
    w_gnt[1]  = w_elig[1] & (~w_elig[0] | ~r_last1);
    w_drop    = w_res_valid & w_tail_valid & w_full[w_tail_id] & ~w_pop[w_tail_id];
    for (int n = 0; n < 2; n++) begin
      w_push[n]    = w_res_valid & w_tail_valid & (w_tail_id == 1'(n)) & ~w_drop;
      // A tail entry with no result (or a dropped write) still frees its credit.
      w_release[n] = w_tail_valid & (w_tail_id == 1'(n)) & (~w_res_valid | w_drop);
    end
    w_err_set = (w_res_valid != w_tail_valid) | w_drop;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_last1     <= 1'b1;
      r_add_valid <= 1'b0;
      r_add_id    <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_op    <= '0;
      r_add_tag   <= '0;
      r_sr_valid  <= '0;
      r_sr_id     <= '0;
      for (int i = 0; i < LAT; i++) r_sr_tag[i] <= '0;
      r_blank     <= BW'(LAT);
      r_err       <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        r_cred[n]   <= '0;
        r_cnt[n]    <= '0;
        r_rd[n]     <= '0;
        r_wr[n]     <= '0;
        r_sticky[n] <= '0;
      end
    end else begin
      r_add_valid <= |w_gnt;
      if (|w_gnt) begin
        r_last1   <= w_gnt[1];
        r_add_id  <= w_gnt[1];
        r_add_a   <= w_gnt[1] ? i_req1_a   : i_req0_a;
        r_add_b   <= w_gnt[1] ? i_req1_b   : i_req0_b;
        r_add_op  <= w_gnt[1] ? i_req1_op  : i_req0_op;
        r_add_tag <= w_gnt[1] ? i_req1_tag : i_req0_tag;
      end
      r_sr_valid[0] <= r_add_valid;
      r_sr_id[0]    <= r_add_id;
      r_sr_tag[0]   <= r_add_tag;
      for (int i = 1; i < LAT; i++) begin
        r_sr_valid[i] <= r_sr_valid[i-1];
        r_sr_id[i]    <= r_sr_id[i-1];
        r_sr_tag[i]   <= r_sr_tag[i-1];
      end
      if (r_blank != '0) r_blank <= r_blank - 1'b1;
      if (w_err_set) r_err <= 1'b1;
      for (int n = 0; n < 2; n++) begin
        if (w_push[n]) r_wr[n] <= r_wr[n] + 1'b1;
        if (w_pop[n])  r_rd[n] <= r_rd[n] + 1'b1;
        r_cnt[n]    <= r_cnt[n] + (AW + 1)'(w_push[n]) - (AW + 1)'(w_pop[n]);
        r_cred[n]   <= r_cred[n] + CW'(w_gnt[n]) - CW'(w_pop[n]) - CW'(w_release[n]);
        r_sticky[n] <= (i_sticky_clr[n] ? 5'b0 : r_sticky[n]) | (w_push[n] ? i_add_flags : 5'b0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_push[n]) begin
        r_mem_data[n][r_wr[n]]  <= i_add_res;
        r_mem_flags[n][r_wr[n]] <= i_add_flags;
        r_mem_tag[n][r_wr[n]]   <= w_tail_tag;
      end
    end
  end

  assign o_req0_ready  = w_gnt[0];
  assign o_req1_ready  = w_gnt[1];
  assign o_add_valid   = r_add_valid;
  assign o_add_a       = r_add_a;
  assign o_add_b       = r_add_b;
  assign o_add_op      = r_add_op;

  // Head fields are forced to zero while empty so reset leaves every output at 0.
  assign o_resp0_valid = (r_cnt[0] != '0);
  assign o_resp0_data  = o_resp0_valid ? r_mem_data[0][r_rd[0]]  : '0;
  assign o_resp0_flags = o_resp0_valid ? r_mem_flags[0][r_rd[0]] : '0;
  assign o_resp0_tag   = o_resp0_valid ? r_mem_tag[0][r_rd[0]]   : '0;
  assign o_resp1_valid = (r_cnt[1] != '0);
  assign o_resp1_data  = o_resp1_valid ? r_mem_data[1][r_rd[1]]  : '0;
  assign o_resp1_flags = o_resp1_valid ? r_mem_flags[1][r_rd[1]] : '0;
  assign o_resp1_tag   = o_resp1_valid ? r_mem_tag[1][r_rd[1]]   : '0;

  assign o_sticky0     = r_sticky[0];
  assign o_sticky1     = r_sticky[1];
  assign o_err         = r_err;

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Bench for fpadd_issue_ctrl: behavioural FP adder plus a per-port queue scoreboard
// that predicts grants, response timing/contents, sticky flags and err.
module tb_fpadd_issue_ctrl;
  localparam int unsigned LAT = 3, DEPTH = 4, TAGW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [TAGW-1:0] req0_tag = 0, req1_tag = 0;
  logic o_add_valid;
  logic [63:0] o_add_a, o_add_b;
  logic [2:0] o_add_op;
  logic add_res_valid;
  logic [63:0] add_res;
  logic [4:0] add_flags;
  logic resp0_valid, resp1_valid, resp0_ready = 0, resp1_ready = 0;
  logic [63:0] resp0_data, resp1_data;
  logic [4:0] resp0_flags, resp1_flags, sticky0, sticky1;
  logic [TAGW-1:0] resp0_tag, resp1_tag;
  logic [1:0] sticky_clr = 0;
  logic err;
  logic inj = 0;

  fpadd_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_a(req0_a),
    .i_req0_b(req0_b), .i_req0_op(req0_op), .i_req0_tag(req0_tag),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_a(req1_a),
    .i_req1_b(req1_b), .i_req1_op(req1_op), .i_req1_tag(req1_tag),
    .o_add_valid(o_add_valid), .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_op(o_add_op),
    .i_add_res_valid(add_res_valid), .i_add_res(add_res), .i_add_flags(add_flags),
    .o_resp0_valid(resp0_valid), .i_resp0_ready(resp0_ready), .o_resp0_data(resp0_data),
    .o_resp0_flags(resp0_flags), .o_resp0_tag(resp0_tag),
    .o_resp1_valid(resp1_valid), .i_resp1_ready(resp1_ready), .o_resp1_data(resp1_data),
    .o_resp1_flags(resp1_flags), .o_resp1_tag(resp1_tag),
    .o_sticky0(sticky0), .o_sticky1(sticky1), .i_sticky_clr(sticky_clr), .o_err(err)
  );

  function automatic logic [4:0] flag_of(input logic [2:0] op);
    case (op)
      3'd0: return 5'b00000;
      3'd1: return 5'b00001;
      3'd2: return 5'b00010;
      3'd3: return 5'b00100;
      3'd4: return 5'b01000;
      3'd5: return 5'b10000;
      default: return 5'b11111;
    endcase
  endfunction

  // Adder environment: LAT-cycle pipeline, real addition, flags from op.
  logic m_v [LAT];
  logic [63:0] m_res [LAT];
  logic [4:0] m_flg [LAT];
  initial for (int i = 0; i < LAT; i++) begin m_v[i] = 0; m_res[i] = 0; m_flg[i] = 0; end
  always @(posedge clk) begin
    m_v[0]   <= o_add_valid;
    m_res[0] <= $realtobits($bitstoreal(o_add_a) + $bitstoreal(o_add_b));
    m_flg[0] <= flag_of(o_add_op);
    for (int i = 1; i < LAT; i++) begin
      m_v[i] <= m_v[i-1]; m_res[i] <= m_res[i-1]; m_flg[i] <= m_flg[i-1];
    end
  end
  assign add_res_valid = m_v[LAT-1] | inj;
  assign add_res       = m_res[LAT-1];
  assign add_flags     = m_flg[LAT-1];

  typedef struct {
    logic [63:0] d; logic [4:0] f; logic [TAGW-1:0] t; int due;
  } ent_t;
  ent_t sq [2][$];
  int cyc = 0;
  bit m_last1 = 1, m_err = 0, p_g = 0;
  logic [4:0] m_sticky [2];
  logic [63:0] p_a = 0, p_b = 0;
  logic [2:0] p_op = 0;
  logic [63:0] drv_a [2], drv_b [2];
  logic [2:0] drv_op [2];
  logic [TAGW-1:0] drv_tag [2];
  int n_checks = 0, n_pass = 0;
  bit rd0, rd1;

  task automatic rand_ops();
    for (int n = 0; n < 2; n++) begin
      drv_a[n]   = $realtobits($itor($urandom_range(0, 1000)));
      drv_b[n]   = $realtobits($itor($urandom_range(0, 1000)));
      drv_op[n]  = 3'($urandom_range(0, 7));
      drv_tag[n] = TAGW'($urandom_range(0, (1 << TAGW) - 1));
    end
  endtask

  // One clock cycle: drive, compare DUT against scoreboard, advance scoreboard.
  task automatic step(input bit v0, input bit v1, input bit r0, input bit r1,
                      input logic [1:0] clr, input bit inj_i, output bit a0, output bit a1);
    bit vv [2], rr [2], e [2], g [2], ev, av;
    logic [63:0] ad; logic [4:0] af, as, wf; logic [TAGW-1:0] at;
    ent_t ne;
    @(negedge clk);
    req0_valid = v0; req0_a = drv_a[0]; req0_b = drv_b[0]; req0_op = drv_op[0]; req0_tag = drv_tag[0];
    req1_valid = v1; req1_a = drv_a[1]; req1_b = drv_b[1]; req1_op = drv_op[1]; req1_tag = drv_tag[1];
    resp0_ready = r0; resp1_ready = r1; sticky_clr = clr; inj = inj_i;
    #1;
    a0 = req0_ready; a1 = req1_ready;
    vv[0] = v0; vv[1] = v1; rr[0] = r0; rr[1] = r1;
    for (int n = 0; n < 2; n++) e[n] = vv[n] && (sq[n].size() < DEPTH);
    if (e[0] && e[1]) begin g[0] = m_last1; g[1] = !m_last1; end
    else begin g[0] = e[0]; g[1] = e[1]; end
    n_checks++; if (req0_ready !== g[0]) $display("FAIL ready0 cyc=%0d got %b exp %b", cyc, req0_ready, g[0]); else n_pass++;
    n_checks++; if (req1_ready !== g[1]) $display("FAIL ready1 cyc=%0d got %b exp %b", cyc, req1_ready, g[1]); else n_pass++;
    n_checks++; if (o_add_valid !== p_g) $display("FAIL add_valid cyc=%0d got %b exp %b", cyc, o_add_valid, p_g); else n_pass++;
    if (p_g) begin
      n_checks++;
      if (o_add_a !== p_a || o_add_b !== p_b || o_add_op !== p_op)
        $display("FAIL add_operands cyc=%0d got %h/%h/%0d exp %h/%h/%0d", cyc, o_add_a, o_add_b, o_add_op, p_a, p_b, p_op);
      else n_pass++;
    end
    n_checks++; if (err !== m_err) $display("FAIL err cyc=%0d got %b exp %b", cyc, err, m_err); else n_pass++;
    for (int n = 0; n < 2; n++) begin
      av = (n == 0) ? resp0_valid : resp1_valid;
      ad = (n == 0) ? resp0_data  : resp1_data;
      af = (n == 0) ? resp0_flags : resp1_flags;
      at = (n == 0) ? resp0_tag   : resp1_tag;
      as = (n == 0) ? sticky0     : sticky1;
      ev = (sq[n].size() > 0) && (sq[n][0].due <= cyc);
      n_checks++; if (av !== ev) $display("FAIL resp%0d_valid cyc=%0d got %b exp %b", n, cyc, av, ev); else n_pass++;
      if (ev) begin
        n_checks++;
        if (ad !== sq[n][0].d || af !== sq[n][0].f || at !== sq[n][0].t)
          $display("FAIL resp%0d_head cyc=%0d got %h/%b/%0d exp %h/%b/%0d", n, cyc, ad, af, at,
                   sq[n][0].d, sq[n][0].f, sq[n][0].t);
        else n_pass++;
      end
      n_checks++; if (as !== m_sticky[n]) $display("FAIL sticky%0d cyc=%0d got %b exp %b", n, cyc, as, m_sticky[n]); else n_pass++;
      wf = 5'b0;
      foreach (sq[n][k]) if (sq[n][k].due == cyc + 1) wf = wf | sq[n][k].f;
      m_sticky[n] = (clr[n] ? 5'b0 : m_sticky[n]) | wf;
      if (ev && rr[n]) void'(sq[n].pop_front());
    end
    if (inj_i) m_err = 1;
    p_g = g[0] | g[1];
    for (int n = 0; n < 2; n++) if (g[n]) begin
      p_a = drv_a[n]; p_b = drv_b[n]; p_op = drv_op[n];
      ne.d = $realtobits($bitstoreal(drv_a[n]) + $bitstoreal(drv_b[n]));
      ne.f = flag_of(drv_op[n]); ne.t = drv_tag[n]; ne.due = cyc + 2 + LAT;
      sq[n].push_back(ne);
      m_last1 = (n == 1);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    sticky_clr = 0; inj = 0;
    @(posedge clk); #1;
    reset_n = 1;
    sq[0].delete(); sq[1].delete();
    m_sticky[0] = 0; m_sticky[1] = 0; m_err = 0; m_last1 = 1; p_g = 0;
    cyc++;
  endtask

  task automatic idle(input int cycles, input bit r0, input bit r1);
    for (int k = 0; k < cycles; k++) step(0, 0, r0, r1, 2'b00, 0, rd0, rd1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_add_valid !== 0 || o_add_a !== 0 || o_add_b !== 0 || o_add_op !== 0)
      $display("FAIL reset_add got %b/%h/%h/%0d exp 0", o_add_valid, o_add_a, o_add_b, o_add_op); else n_pass++;
    n_checks++; if (resp0_valid !== 0 || resp1_valid !== 0 || resp0_data !== 0)
      $display("FAIL reset_resp got %b/%b/%h exp 0", resp0_valid, resp1_valid, resp0_data); else n_pass++;
    n_checks++; if (sticky0 !== 0 || sticky1 !== 0 || err !== 0)
      $display("FAIL reset_flags got %b/%b/%b exp 0", sticky0, sticky1, err); else n_pass++;
  endtask

  task automatic test_single();
    drv_a[0] = 64'h3FF0000000000000; drv_b[0] = 64'h4000000000000000; drv_op[0] = 0; drv_tag[0] = 5;
    step(1, 0, 1, 1, 2'b00, 0, rd0, rd1);
    n_checks++; if (rd0 !== 1) $display("FAIL single_ready got %b exp 1", rd0); else n_pass++;
    for (int k = 1; k <= LAT + 3; k++) begin
      step(0, 0, 1, 1, 2'b00, 0, rd0, rd1);
      if (k == 1) begin
        n_checks++; if (o_add_valid !== 1) $display("FAIL single_issue got %b exp 1", o_add_valid); else n_pass++;
      end
      if (k == LAT + 1) begin
        n_checks++; if (resp0_valid !== 0) $display("FAIL single_early got %b exp 0", resp0_valid); else n_pass++;
      end
      if (k == LAT + 2) begin
        n_checks++;
        if (resp0_valid !== 1 || resp0_data !== 64'h4008000000000000 || resp0_tag !== 5)
          $display("FAIL single_resp got %b/%h/%0d exp 1/4008000000000000/5", resp0_valid, resp0_data, resp0_tag);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      rand_ops(); drv_tag[0] = TAGW'(k); drv_tag[1] = TAGW'(k);
      step(1, 1, 1, 1, 2'b00, 0, rd0, rd1);
      n_checks++;
      if (rd0 !== (k % 2 == 0) || rd1 !== (k % 2 == 1))
        $display("FAIL b2b_alt k=%0d got %b%b exp %b%b", k, rd0, rd1, (k % 2 == 0), (k % 2 == 1));
      else n_pass++;
    end
    idle(LAT + 3, 1, 1);
  endtask

  task automatic test_credit();
    int c0 = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      rand_ops(); step(1, 1, 0, 1, 2'b00, 0, rd0, rd1); c0 += int'(rd0);
      if (k >= 7) begin
        n_checks++; if (rd0 !== 0) $display("FAIL credit_block k=%0d got %b exp 0", k, rd0); else n_pass++;
      end
    end
    n_checks++; if (c0 != DEPTH) $display("FAIL credit_count got %0d exp %0d", c0, DEPTH); else n_pass++;
    rand_ops(); step(1, 1, 1, 1, 2'b00, 0, rd0, rd1); c0 += int'(rd0);
    for (int k = 0; k < 4; k++) begin
      rand_ops(); step(1, 1, 0, 1, 2'b00, 0, rd0, rd1); c0 += int'(rd0);
    end
    n_checks++; if (c0 != DEPTH + 1) $display("FAIL credit_refill got %0d exp %0d", c0, DEPTH + 1); else n_pass++;
    idle(DEPTH + LAT + 4, 1, 1);
  endtask

  task automatic test_sticky();
    do_reset();
    rand_ops();
    drv_op[1] = 3'd5; step(0, 1, 1, 1, 2'b00, 0, rd0, rd1);
    drv_op[1] = 3'd1; step(0, 1, 1, 1, 2'b00, 0, rd0, rd1);
    idle(LAT + 3, 1, 1);
    n_checks++; if (sticky1 !== 5'b10001) $display("FAIL sticky_accum got %b exp 10001", sticky1); else n_pass++;
    drv_op[1] = 3'd5; step(0, 1, 1, 1, 2'b00, 0, rd0, rd1);
    drv_op[1] = 3'd1; step(0, 1, 1, 1, 2'b00, 0, rd0, rd1);
    for (int k = 2; k <= LAT + 3; k++) begin
      step(0, 0, 1, 1, (k == LAT + 2) ? 2'b10 : 2'b00, 0, rd0, rd1);
      if (k == LAT + 2) begin
        n_checks++; if (sticky1 !== 5'b10001) $display("FAIL sticky_pre got %b exp 10001", sticky1); else n_pass++;
      end
    end
    n_checks++; if (sticky1 !== 5'b00001) $display("FAIL sticky_clr got %b exp 00001", sticky1); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    do_reset();
    rand_ops(); step(1, 0, 0, 1, 2'b00, 0, rd0, rd1);
    rand_ops(); step(1, 0, 0, 1, 2'b00, 0, rd0, rd1);
    idle(LAT + 2, 0, 1);
    rand_ops(); step(1, 0, 0, 1, 2'b00, 0, rd0, rd1);
    rand_ops(); step(1, 0, 0, 1, 2'b00, 0, rd0, rd1);
    do_reset();
    n_checks++; if (resp0_valid !== 0 || o_add_valid !== 0 || err !== 0)
      $display("FAIL midreset_clear got %b/%b/%b exp 0/0/0", resp0_valid, o_add_valid, err); else n_pass++;
    idle(LAT + 3, 1, 1);
    n_checks++; if (err !== 0 || resp0_valid !== 0) $display("FAIL midreset_stale got %b/%b exp 0/0", err, resp0_valid); else n_pass++;
    rand_ops(); step(1, 0, 1, 1, 2'b00, 0, rd0, rd1);
    n_checks++; if (rd0 !== 1) $display("FAIL midreset_issue got %b exp 1", rd0); else n_pass++;
    for (int k = 1; k <= LAT + 3; k++) begin
      step(0, 0, 1, 1, 2'b00, 0, rd0, rd1);
      if (resp0_valid === 1) seen = 1;
    end
    n_checks++; if (!seen) $display("FAIL midreset_resp got 0 exp 1"); else n_pass++;
  endtask

  task automatic test_err();
    logic [63:0] head;
    do_reset();
    rand_ops(); step(1, 0, 0, 1, 2'b00, 0, rd0, rd1);
    rand_ops(); step(1, 0, 0, 1, 2'b00, 0, rd0, rd1);
    idle(LAT + 3, 0, 1);
    head = sq[0][0].d;
    step(0, 0, 0, 1, 2'b00, 1, rd0, rd1);
    idle(4, 0, 1);
    n_checks++; if (err !== 1) $display("FAIL err_set got %b exp 1", err); else n_pass++;
    n_checks++; if (resp0_valid !== 1 || resp0_data !== head)
      $display("FAIL err_fifo got %b/%h exp 1/%h", resp0_valid, resp0_data, head); else n_pass++;
    idle(4, 1, 1);
    n_checks++; if (err !== 1) $display("FAIL err_hold got %b exp 1", err); else n_pass++;
  endtask

  initial begin
    m_sticky[0] = 0; m_sticky[1] = 0;
    rand_ops();
    test_reset();
    test_single();
    test_back_to_back();
    test_credit();
    test_sticky();
    test_reset_midflight();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
